spike_event_logger: RTL and testbench
=====================================

# spike_event_logger

Records output spikes from the LIF neuron stage as timestamped events in a small FIFO for later readout. It sits directly downstream of the neuron, driven by the neuron's 1-bit spike output. It converts the spike pulse train into a buffered stream of event times that a host-side reader drains through a valid/pop handshake. It also counts events dropped on overflow.

## Interface

Parameters:
- TS_W, 8: timestamp/interval width in bits.
- DEPTH, 4: FIFO entries; must be a power of two, ≥2.

Ports:
- clk  input  1  single clock, all state on rising edge.
- reset  input  1  asynchronous, active-high reset; clears all state immediately.
- spike_in  input  1  spike from the LIF neuron.
- pop  input  1  reader consumes head entry this cycle.
- clear_drops  input  1  synchronous clear of drop_cnt and overflow.
- valid  output  1  FIFO non-empty; ev_data is meaningful.
- ev_data  output  TS_W  head entry (timestamp or interval).
- level  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- drop_cnt  output  8  events lost to full FIFO, saturating at 255.
- overflow  output  1  sticky: at least one event dropped since last clear/reset.

## Operation

- Timestamp counter ts_cnt (TS_W bits): increments every cycle and wraps from 2^TS_W-1 to 0.
- Edge detect: spk_q holds the previous spike_in.
  - An event occurs in a cycle where spike_in=1 and spk_q=0.
  - A spike held high for multiple cycles is one event.
- Event payload is the pre-edge value of ts_cnt in the event cycle, or the interval value when SPIKE_LOG_ISI_EN is defined.
- FIFO: circular buffer with wr_ptr/rd_ptr and an occupancy count.
  - ev_data = mem[rd_ptr], driven combinationally from storage.
  - ev_data is don't-care when valid=0; the bench must not check it then.
- Push on event when not full. If full, the event is dropped: drop_cnt increments (saturating) and overflow is set.
- Pop when pop=1 and valid=1. A pop while empty is ignored with no state change.
- Simultaneous push and pop:
  - When full: the pop frees a slot, the push is accepted, no drop occurs, and level stays at DEPTH.
  - When empty: the pop is ignored, the push is accepted, and level becomes 1.
  - Otherwise: both happen and level is unchanged.
- clear_drops=1 zeroes drop_cnt and overflow. If a drop occurs in the same cycle, the clear wins and the result is 0.
- Pointers wrap modulo DEPTH.

## Timing

- Reset values:
  - valid=0, level=0, drop_cnt=0, overflow=0.
  - ts_cnt=0, spk_q=0, and the interval counter is 0.
  - ev_data is don't-care.
- Latency: an event detected before rising edge N is written at edge N, and valid/level update after edge N. Spike-to-valid latency is one cycle.
- Pop takes effect at the edge. The next entry, or valid=0, appears after that edge.
- The first edge after reset deassertion moves ts_cnt from 0 to 1. An event sampled at that edge stores 0.
- Reset asserted mid-operation discards all FIFO contents and counters asynchronously. Outputs take reset values without waiting for a clock.
- No combinational path from spike_in to any output. pop affects outputs only through registers.

## Configuration

- SPIKE_LOG_ISI_EN defined: the payload is the inter-spike interval instead of the absolute timestamp.
  - isi_cnt (TS_W bits) is 0 at reset.
  - Each cycle: isi_cnt becomes 1 on an event; otherwise it increments, saturating at 2^TS_W-1.
  - The payload is the pre-edge isi_cnt, so events k cycles apart store k.
  - The first event stores the cycles elapsed since reset, saturated.
  - ts_cnt still runs but is unused.
- Not defined: absolute ts_cnt payload, and no isi_cnt register exists.

## Test plan

- Reset release, then a single-cycle spike at ts_cnt=5 → one cycle later valid=1, ev_data=5, level=1; pop → valid=0, level=0.
- spike_in held high for 4 cycles starting at ts=10 → exactly one entry (10), level=1.
- Defaults: 6 isolated spikes with no pops → level=4, holding the first 4 timestamps in order; drop_cnt=2, overflow=1. Then clear_drops → both 0 and FIFO contents intact.
- Full FIFO with spike and pop in the same cycle → head popped, new timestamp appended at the tail, level=4, drop_cnt unchanged.
- Spike at ts=254 and again 4 cycles later → entries 254 then 2 (wrap).
- Reset asserted asynchronously mid-stream with level=3 → valid=0, level=0, drop_cnt=0 before the next edge.
- With SPIKE_LOG_ISI_EN defined: spikes 7 cycles apart → ev_data=7; spikes 300 cycles apart → ev_data=255.

Source files
------------

// File: rtl/spike_event_logger.sv
// spike_event_logger: buffers rising edges of the LIF spike output as timestamped events in a small FIFO.
// Optional macro SPIKE_LOG_ISI_EN stores the inter-spike interval instead of the absolute timestamp.
module spike_event_logger #(
    parameter int TS_W  = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   spike_in,
    input  logic                   pop,
    input  logic                   clear_drops,
    output logic                   valid,
    output logic [TS_W-1:0]        ev_data,
    output logic [$clog2(DEPTH):0] level,
    output logic [7:0]             drop_cnt,
    output logic                   overflow
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0]     FULL_LVL = DEPTH[PW:0];
    localparam logic [PW:0]     LVL_ZERO = (PW+1)'(1'b0);
    localparam logic [PW:0]     LVL_ONE  = (PW+1)'(1'b1);
    localparam logic [PW-1:0]   PTR_ONE  = PW'(1'b1);
    localparam logic [TS_W-1:0] TS_ONE   = TS_W'(1'b1);

    logic [TS_W-1:0] ts_cnt;
    logic            spk_q;
    logic [TS_W-1:0] mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [PW:0]     count;
    logic [PW:0]     count_next;
    logic [TS_W-1:0] payload;
    logic            spike_edge;
    logic            full;
    logic            do_push;
    logic            do_pop;
    logic            do_drop;

    // Edge detect and push/pop/drop arbitration; a pop on a full FIFO frees the slot for a same-cycle push.
    always_comb begin
        spike_edge = spike_in & ~spk_q;
        full       = (count == FULL_LVL);
        do_pop     = pop & (count != LVL_ZERO);
        do_push    = spike_edge & (~full | do_pop);
        do_drop    = spike_edge & full & ~do_pop;
        count_next = count;
        case ({do_push, do_pop})
            2'b10:   count_next = count + LVL_ONE;
            2'b01:   count_next = count - LVL_ONE;
            default: count_next = count;
        endcase
    end

`ifdef SPIKE_LOG_ISI_EN
    logic [TS_W-1:0] isi_cnt;

    // Interval counter: restarts at one on each event, otherwise counts up and saturates.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            isi_cnt <= {TS_W{1'b0}};
        end else if (spike_edge) begin
            isi_cnt <= TS_ONE;
        end else if (isi_cnt != {TS_W{1'b1}}) begin
            isi_cnt <= isi_cnt + TS_ONE;
        end else begin
            isi_cnt <= isi_cnt;
        end
    end

    assign payload = isi_cnt;
`else
    assign payload = ts_cnt;
`endif

    // Free-running timestamp, spike history, FIFO pointers and occupancy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ts_cnt <= {TS_W{1'b0}};
            spk_q  <= 1'b0;
            wr_ptr <= {PW{1'b0}};
            rd_ptr <= {PW{1'b0}};
            count  <= LVL_ZERO;
            valid  <= 1'b0;
        end else begin
            ts_cnt <= ts_cnt + TS_ONE;
            spk_q  <= spike_in;
            wr_ptr <= do_push ? wr_ptr + PTR_ONE : wr_ptr;
            rd_ptr <= do_pop ? rd_ptr + PTR_ONE : rd_ptr;
            count  <= count_next;
            valid  <= (count_next != LVL_ZERO);
        end
    end

    // Event storage; contents are meaningless while empty so no reset is needed.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= payload;
        end
    end

    // Drop accounting; a clear in the same cycle as a drop wins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drop_cnt <= 8'd0;
            overflow <= 1'b0;
        end else if (clear_drops) begin
            drop_cnt <= 8'd0;
            overflow <= 1'b0;
        end else if (do_drop) begin
            drop_cnt <= (drop_cnt == 8'hFF) ? drop_cnt : drop_cnt + 8'd1;
            overflow <= 1'b1;
        end else begin
            drop_cnt <= drop_cnt;
            overflow <= overflow;
        end
    end

    assign level   = count;
    assign ev_data = mem[rd_ptr];

endmodule

// File: tb/tb_spike_event_logger.sv
// Scoreboard bench for spike_event_logger: stimulus queues expected payloads, a negedge monitor checks each pop.
module tb_spike_event_logger;
    logic       clk;
    logic       reset;
    logic       spike_in;
    logic       pop;
    logic       clear_drops;
    logic       valid;
    logic [7:0] ev_data;
    logic [2:0] level;
    logic [7:0] drop_cnt;
    logic       overflow;

    int         tests = 0;
    int         fails = 0;
    int         cyc;
    logic [7:0] exp_q[$];

    spike_event_logger #(.TS_W(8), .DEPTH(4)) dut (
        .clk(clk), .reset(reset), .spike_in(spike_in), .pop(pop),
        .clear_drops(clear_drops), .valid(valid), .ev_data(ev_data),
        .level(level), .drop_cnt(drop_cnt), .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edges completed since reset release; the next edge samples timestamp cyc mod 256.
    always @(posedge clk or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every accepted pop must present the oldest expected payload.
    always @(negedge clk) begin
        if (!reset && valid && pop) begin
            if (exp_q.size() == 0) chk("pop_unexpected_entry", exp_q.size(), 1);
            else                   chk("pop_data", int'(ev_data), int'(exp_q.pop_front()));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cyc(input int target);
        int n = 0;
        while (cyc < target && n < 1000) begin
            step();
            n++;
        end
        if (cyc != target) chk("wait_cyc_timeout", cyc, target);
    endtask

    task automatic pulse_at(input int c, input logic [7:0] exp, input bit accept);
        wait_cyc(c);
        spike_in = 1'b1;
        step();
        spike_in = 1'b0;
        if (accept) exp_q.push_back(exp);
    endtask

    task automatic pop_one();
        pop = 1'b1;
        step();
        pop = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; spike_in = 1'b0; pop = 1'b0; clear_drops = 1'b0;
        #12;
        chk("reset_valid", valid, 0);
        chk("reset_level", level, 0);
        chk("reset_drop_cnt", drop_cnt, 0);
        chk("reset_overflow", overflow, 0);
        #10 reset = 1'b0;

`ifdef SPIKE_LOG_ISI_EN
        pulse_at(3, 8'd3, 1'b1);
        chk("isi_first_level", level, 1);
        chk("isi_first_data", ev_data, 3);
        pop_one();
        pulse_at(10, 8'd7, 1'b1);
        chk("isi_7_data", ev_data, 7);
        pop_one();
        pulse_at(310, 8'd255, 1'b1);
        chk("isi_300_data", ev_data, 255);
        chk("isi_300_level", level, 1);
        pop_one();
        chk("isi_drained_valid", valid, 0);
        chk("isi_queue_empty", exp_q.size(), 0);
`else
        pulse_at(5, 8'd5, 1'b1);
        chk("single_valid", valid, 1);
        chk("single_level", level, 1);
        chk("single_data", ev_data, 5);
        pop_one();
        chk("single_pop_valid", valid, 0);
        chk("single_pop_level", level, 0);

        wait_cyc(10);
        spike_in = 1'b1;
        repeat (4) step();
        spike_in = 1'b0;
        exp_q.push_back(8'd10);
        chk("held_level", level, 1);
        chk("held_data", ev_data, 10);
        pop_one();

        for (int i = 0; i < 6; i++) pulse_at(20 + 2*i, 8'(20 + 2*i), i < 4);
        chk("fill_level", level, 4);
        chk("fill_drop_cnt", drop_cnt, 2);
        chk("fill_overflow", overflow, 1);
        chk("fill_head", ev_data, 20);
        clear_drops = 1'b1;
        step();
        clear_drops = 1'b0;
        chk("clear_drop_cnt", drop_cnt, 0);
        chk("clear_overflow", overflow, 0);
        chk("clear_level", level, 4);
        chk("clear_head", ev_data, 20);

        wait_cyc(40);
        spike_in = 1'b1; pop = 1'b1;
        step();
        spike_in = 1'b0; pop = 1'b0;
        exp_q.push_back(8'd40);
        chk("fullpp_level", level, 4);
        chk("fullpp_drop_cnt", drop_cnt, 0);
        chk("fullpp_head", ev_data, 22);

        wait_cyc(50);
        spike_in = 1'b1; clear_drops = 1'b1;
        step();
        spike_in = 1'b0; clear_drops = 1'b0;
        chk("clear_vs_drop_cnt", drop_cnt, 0);
        chk("clear_vs_drop_ovf", overflow, 0);
        chk("clear_vs_drop_level", level, 4);

        repeat (4) pop_one();
        chk("drain_valid", valid, 0);
        chk("drain_queue", exp_q.size(), 0);
        pop_one();
        chk("empty_pop_level", level, 0);
        chk("empty_pop_valid", valid, 0);

        wait_cyc(60);
        spike_in = 1'b1; pop = 1'b1;
        step();
        spike_in = 1'b0; pop = 1'b0;
        exp_q.push_back(8'd60);
        chk("emptypp_level", level, 1);
        chk("emptypp_data", ev_data, 60);
        pop_one();

        pulse_at(254, 8'd254, 1'b1);
        pulse_at(258, 8'd2, 1'b1);
        chk("wrap_level", level, 2);
        chk("wrap_head", ev_data, 254);
        pop_one();
        pop_one();

        for (int i = 0; i < 5; i++) pulse_at(266 + 2*i, 8'(10 + 2*i), i < 4);
        pop_one();
        chk("pre_reset_level", level, 3);
        chk("pre_reset_drop_cnt", drop_cnt, 1);
        #2 reset = 1'b1;
        #1;
        chk("async_valid", valid, 0);
        chk("async_level", level, 0);
        chk("async_drop_cnt", drop_cnt, 0);
        chk("async_overflow", overflow, 0);
        exp_q.delete();
        #10 reset = 1'b0;
        pulse_at(3, 8'd3, 1'b1);
        chk("post_reset_data", ev_data, 3);
        chk("post_reset_level", level, 1);
        pop_one();
`endif
        chk("final_queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
